// File: rtl/comparator_seq_if.sv
// Handshake and result bundle for comparator_seq: operand request channel,
// result response channel and the running match counter.
interface comparator_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data_1;
  logic [WIDTH-1:0] in_data_2;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             result_eq;
  logic             result_lt;
  logic             result_gt;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in_data_1, in_data_2, in_signed, out_ready,
    input  in_ready, out_valid, result_eq, result_lt, result_gt, match_count
  );

  modport slave (
    input  in_valid, in_data_1, in_data_2, in_signed, out_ready,
    output in_ready, out_valid, result_eq, result_lt, result_gt, match_count
  );
endinterface

// File: rtl/comparator_seq.sv
// Sequential magnitude comparator: walks CHUNK-bit slices from the MSB end and
// stops at the first differing slice; counts delivered equal results.
module comparator_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  comparator_seq_if.slave bus
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             signed_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] a_adj;
  logic [WIDTH-1:0] b_adj;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  int unsigned      base;

  // Flipping the sign bit of both operands turns a signed compare into an
  // unsigned one; only the top slice is affected.
  always_comb begin
    a_adj   = op_a_q ^ {signed_q, {(WIDTH-1){1'b0}}};
    b_adj   = op_b_q ^ {signed_q, {(WIDTH-1){1'b0}}};
    base    = 32'(idx_q) * CHUNK;
    slice_a = a_adj[base +: CHUNK];
    slice_b = b_adj[base +: CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      signed_q <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_a_q   <= bus.in_data_1;
            op_b_q   <= bus.in_data_2;
            signed_q <= bus.in_signed;
            idx_q    <= IdxW'(NumChunks - 1);
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (slice_a != slice_b) begin
            eq_q    <= 1'b0;
            lt_q    <= (slice_a < slice_b);
            gt_q    <= (slice_a > slice_b);
            state_q <= StDone;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
            if (eq_q && (count_q != {CNT_W{1'b1}})) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.result_eq   = eq_q;
  assign bus.result_lt   = lt_q;
  assign bus.result_gt   = gt_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq: directed cases, back-pressure, reset
// abort, randomized operands against an arithmetic model, and counter saturation.
module tb_comparator_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NCH   = WIDTH / CHUNK;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_count;

  comparator_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic compare; latency from first differing slice.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, output logic eq, output logic lt,
                                output logic gt, output int lat);
    eq = (a == b);
    if (s) lt = ($signed(a) < $signed(b));
    else   lt = (a < b);
    gt  = !eq && !lt;
    lat = NCH + 1;
    for (int k = 1; k <= int'(NCH); k++) begin
      if (a[WIDTH - k*CHUNK +: CHUNK] != b[WIDTH - k*CHUNK +: CHUNK]) begin
        lat = k + 1;
        break;
      end
    end
  endfunction

  // Offers one operand pair and waits (bounded) for out_valid; lat counts the
  // accept cycle as 1.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, output logic eq, output logic lt,
                        output logic gt, output int lat);
    bus.in_data_1 = a;
    bus.in_data_2 = b;
    bus.in_signed = s;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    eq = bus.result_eq;
    lt = bus.result_lt;
    gt = bus.result_gt;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_signed = 1'b0;
    bus.in_data_1 = '0;  bus.in_data_2 = '0;
    #12;
    checks++;
    if ({bus.out_valid, bus.result_eq, bus.result_lt, bus.result_gt} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000",
               {bus.out_valid, bus.result_eq, bus.result_lt, bus.result_gt});
    end
    checks++;
    if (bus.match_count !== '0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", bus.match_count);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    exp_count = 0;
  endtask

  // Runs one op, checks results, latency and counter after delivery.
  task automatic check_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic s);
    logic eq, lt, gt, e_eq, e_lt, e_gt;
    int   lat, e_lat;
    model(a, b, s, e_eq, e_lt, e_gt, e_lat);
    run_op(a, b, s, eq, lt, gt, lat);
    checks++;
    if ({eq, lt, gt} !== {e_eq, e_lt, e_gt}) begin
      failures++;
      $display("FAIL %s_result a=%h b=%h s=%b got eq/lt/gt=%b want=%b",
               name, a, b, s, {eq, lt, gt}, {e_eq, e_lt, e_gt});
    end
    checks++;
    if (lat !== e_lat) begin
      failures++;
      $display("FAIL %s_latency a=%h b=%h got=%0d want=%0d", name, a, b, lat, e_lat);
    end
    pop();
    if (e_eq && exp_count < CMAX) exp_count++;
    checks++;
    if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
      failures++;
      $display("FAIL %s_release got valid/ready=%b%b want=01", name,
               bus.out_valid, bus.in_ready);
    end
    checks++;
    if (int'(bus.match_count) !== exp_count) begin
      failures++;
      $display("FAIL %s_count got=%0d want=%0d", name, bus.match_count, exp_count);
    end
  endtask

  task automatic test_directed();
    check_op("eq_1234",    16'h1234, 16'h1234, 1'b0);
    check_op("u_8000",     16'h8000, 16'h1000, 1'b0);
    check_op("s_8000",     16'h8000, 16'h1000, 1'b1);
    check_op("u_1235",     16'h1235, 16'h1234, 1'b0);
    check_op("s_ffff",     16'hFFFF, 16'h0000, 1'b1);
  endtask

  task automatic test_backpressure();
    logic eq, lt, gt;
    int   lat;
    run_op(16'h1235, 16'h1234, 1'b0, eq, lt, gt, lat);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = i[0];
      bus.in_data_1 = 16'h0000;
      bus.in_data_2 = 16'hFFFF;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result_eq, bus.result_lt, bus.result_gt}
          !== 5'b10001) begin
        failures++;
        $display("FAIL hold_cycle%0d got v/r/eq/lt/gt=%b want=10001", i,
                 {bus.out_valid, bus.in_ready, bus.result_eq, bus.result_lt,
                  bus.result_gt});
      end
    end
    bus.in_valid = 1'b0;
    pop();
    checks++;
    if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
      failures++;
      $display("FAIL hold_release got valid/ready=%b%b want=01", bus.out_valid,
               bus.in_ready);
    end
  endtask

  task automatic test_reset_abort();
    rst_n = 1'b0; #3; rst_n = 1'b1;
    exp_count = 0;
    @(posedge clk); #1;
    bus.in_data_1 = 16'h5A5A; bus.in_data_2 = 16'h5A5A; bus.in_signed = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.result_eq, bus.result_lt, bus.result_gt} !== 4'b0000 ||
        bus.match_count !== '0) begin
      failures++;
      $display("FAIL abort_outputs got v/eq/lt/gt=%b cnt=%0d want=0000 cnt=0",
               {bus.out_valid, bus.result_eq, bus.result_lt, bus.result_gt},
               bus.match_count);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.match_count !== '0) begin
        failures++;
        $display("FAIL abort_idle%0d got v/r=%b%b cnt=%0d want=01 cnt=0", i,
                 bus.out_valid, bus.in_ready, bus.match_count);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic             s;
    for (int n = 0; n < 40; n++) begin
      a = WIDTH'($urandom);
      b = a;
      case ($urandom_range(0, 3))
        0: b = WIDTH'($urandom);
        1: b[$urandom_range(0, WIDTH-1)] = ~b[$urandom_range(0, WIDTH-1)];
        2: b[WIDTH-1] = ~b[WIDTH-1];
        default: ;
      endcase
      s = 1'($urandom);
      check_op("rand", a, b, s);
    end
  endtask

  task automatic test_saturation();
    logic [WIDTH-1:0] a;
    for (int n = 0; n < 260; n++) begin
      a = WIDTH'($urandom);
      check_op("sat", a, a, 1'($urandom));
    end
    checks++;
    if (int'(bus.match_count) !== CMAX) begin
      failures++;
      $display("FAIL sat_final got=%0d want=%0d", bus.match_count, CMAX);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_count = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_reset_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_seq.md
COMPARATOR_SEQ -- requirements
Module: comparator_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per cycle.
REQ-003 Parameter CNT_W, default 8, width of match counter.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 in_data_1  input  WIDTH  first operand.
REQ-009 in_data_2  input  WIDTH  second operand.
REQ-010 in_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result_eq / result_lt / result_gt  output  1 each  in_data_1 ==, <, > in_data_2; exactly one high when out_valid=1.
REQ-014 match_count  output  CNT_W  number of delivered results with result_eq=1.

Function
REQ-015 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&&in_ready, register both operands and in_signed, load chunk index with WIDTH/CHUNK-1, go BUSY; otherwise stay IDLE.
REQ-017 BUSY: each cycle compare one CHUNK-bit slice of both operands, MSB slice first, as unsigned values.
REQ-018 Signed mode: the operand MSB is inverted in both operands before the top slice is compared; no other slice modified.
REQ-019 BUSY, slices differ: set result_lt or result_gt from the slice comparison, clear the others, go DONE (early termination).
REQ-020 BUSY, slices equal and index=0: set result_eq, clear lt/gt, go DONE; slices equal and index>0: decrement index, stay BUSY.
REQ-021 Latency: decision at first differing slice from the top, slice position k (1..WIDTH/CHUNK) -> out_valid rises k+1 cycles after the accepting edge; equal operands -> WIDTH/CHUNK+1.
REQ-022 DONE: result_* and out_valid held stable while out_ready=0; on out_ready=1 go IDLE, out_valid falls next cycle.
REQ-023 Operand inputs ignored outside IDLE; in_valid while busy is not lost in protocol sense (in_ready=0 stalls the producer).
REQ-024 match_count increments by 1 on out_valid&&out_ready&&result_eq; saturates at 2^CNT_W-1, never wraps.
REQ-025 result_* outputs retain last values in IDLE and BUSY (only meaningful with out_valid).

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, in_ready=1 once released (0 is not required during reset), out_valid=0, result_eq/lt/gt=0, match_count=0, index=0, operand registers=0.
REQ-027 Reset asserted in BUSY or DONE aborts the operation; no result delivered, match_count not incremented.
REQ-028 First accept permitted on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, CHUNK=4, CNT_W=8)
REQ-029 0x1234 vs 0x1234, unsigned, out_ready=1 -> 4 BUSY cycles, out_valid 5 cycles after accept, result_eq=1, match_count 0->1.
REQ-030 0x8000 vs 0x1000: unsigned -> result_gt=1 after 1 BUSY cycle (out_valid at +2); signed -> result_lt=1, same latency.
REQ-031 0x1235 vs 0x1234 unsigned -> result_gt=1 after 4 BUSY cycles; 0xFFFF vs 0x0000 signed -> result_lt=1 after 1 BUSY cycle.
REQ-032 out_ready held 0 for 3 cycles in DONE -> out_valid and result_* stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-033 rst_n pulsed low during BUSY of an equal pair -> outputs at reset values immediately, no out_valid, match_count unchanged at 0.
REQ-034 260 back-to-back equal pairs -> match_count reaches 255 and stays 255.
